// File: rtl/rv32_decode_stage.sv
// rtl/rv32_decode_stage.sv - RV32I OP/OP-IMM decode and operand-read stage with 32x32 register file.
// Optional write-first forwarding from the writeback port is enabled by defining RV32_DECODE_BYPASS_EN.
module rv32_decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] x1,
  output logic [31:0] x2,
  output logic [19:0] instr,
  output logic        opcode_4,
  output logic        cin,
  output logic [4:0]  rd,
  output logic        illegal
);

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state_q;
  logic [XLEN-1:0]   rf_q [NREG];
  logic [XLEN-1:0]   x1_q, x2_q, x1_d, x2_d;
  logic [19:0]       instr_q;
  logic              opcode_4_q, opcode_4_d;
  logic [4:0]        rd_q, rd_d;
  logic              illegal_q, illegal_d;

  logic [6:0]        opc;
  logic [4:0]        rs1, rs2;
  logic              legal;
  logic              accept;

  assign opc      = in_instr[6:0];
  assign rs1      = in_instr[19:15];
  assign rs2      = in_instr[24:20];
  assign legal    = (opc == OPC_OP) || (opc == OPC_OP_IMM);
  assign in_ready = (state_q == EMPTY) || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    x1_d       = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    x2_d       = (rs2 == 5'd0) ? '0 : rf_q[rs2];
`ifdef RV32_DECODE_BYPASS_EN
    if (wb_en && (wb_rd == rs1) && (rs1 != 5'd0)) x1_d = wb_data;
    if (wb_en && (wb_rd == rs2) && (rs2 != 5'd0)) x2_d = wb_data;
`else
`endif
    opcode_4_d = legal ? in_instr[5] : 1'b0;
    rd_d       = legal ? in_instr[11:7] : 5'd0;
    illegal_d  = ~legal;
  end

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_en && (wb_rd != 5'd0)) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      x1_q       <= '0;
      x2_q       <= '0;
      instr_q    <= '0;
      opcode_4_q <= 1'b0;
      rd_q       <= '0;
      illegal_q  <= 1'b0;
    end else if (accept) begin
      state_q    <= FULL;
      x1_q       <= x1_d;
      x2_q       <= x2_d;
      instr_q    <= in_instr[31:12];
      opcode_4_q <= opcode_4_d;
      rd_q       <= rd_d;
      illegal_q  <= illegal_d;
    end else if (out_ready) begin
      state_q    <= EMPTY;
    end
  end

  assign out_valid = (state_q == FULL);
  assign x1        = x1_q;
  assign x2        = x2_q;
  assign instr     = instr_q;
  assign opcode_4  = opcode_4_q;
  assign cin       = 1'b0;
  assign rd        = rd_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// tb/tb_rv32_decode_stage.sv - scoreboard bench for rv32_decode_stage against a behavioural model.
module tb_rv32_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        in_ready;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] x1, x2;
  logic [19:0] instr;
  logic        opcode_4, cin;
  logic [4:0]  rd;
  logic        illegal;

  rv32_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .x1(x1), .x2(x2), .instr(instr), .opcode_4(opcode_4), .cin(cin), .rd(rd), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] x1;
    logic [31:0] x2;
    logic [19:0] ins;
    logic        op4;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] regs [32];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] read_reg(input logic [4:0] r, input logic we,
                                           input logic [4:0] wr, input logic [31:0] wd);
    if (r == 0) return 32'd0;
`ifdef RV32_DECODE_BYPASS_EN
    if (we && wr == r) return wd;
`endif
    return regs[r];
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic we,
                                 input logic [4:0] wr, input logic [31:0] wd);
    exp_t e;
    logic is_op, is_imm;
    is_op  = (ins[6:0] == 7'h33);
    is_imm = (ins[6:0] == 7'h13);
    e.x1  = read_reg(ins[19:15], we, wr, wd);
    e.x2  = read_reg(ins[24:20], we, wr, wd);
    e.ins = ins[31:12];
    e.op4 = is_op;
    e.rd  = (is_op || is_imm) ? ins[11:7] : 5'd0;
    e.ill = !(is_op || is_imm);
    return e;
  endfunction

  function automatic logic [31:0] make_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [4:0] rdd, input logic [6:0] opc);
    return {7'd0, rs2, rs1, 3'd0, rdd, opc};
  endfunction

  task automatic cycle(input logic v, input logic [31:0] ins, input logic we,
                       input logic [4:0] wr, input logic [31:0] wd, input logic ordy);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_instr  = ins;
    wb_en     = we;
    wb_rd     = wr;
    wb_data   = wd;
    out_ready = ordy;
    @(negedge clk);
    if (in_valid && in_ready) sb_q.push_back(model(ins, we, wr, wd));
    if (we && wr != 0) regs[wr] = wd;
  endtask

  // Monitor: checks handshake, pops the scoreboard on transfer, and checks stability while stalled.
  exp_t        snap;
  logic        have_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    exp_t cur;
    if (rst_n) begin
      chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
      cur = '{x1: x1, x2: x2, ins: instr, op4: opcode_4, rd: rd, ill: illegal};
      if (out_valid) begin
        if (have_prev) begin
          chk("stall_hold_x1", cur.x1, snap.x1);
          chk("stall_hold_x2", cur.x2, snap.x2);
          chk("stall_hold_instr", {12'd0, cur.ins}, {12'd0, snap.ins});
          chk("stall_hold_rd", {27'd0, cur.rd}, {27'd0, snap.rd});
        end
        if (out_ready) begin
          have_prev = 1'b0;
          if (sb_q.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk("x1", cur.x1, e.x1);
            chk("x2", cur.x2, e.x2);
            chk("instr", {12'd0, cur.ins}, {12'd0, e.ins});
            chk("opcode_4", {31'd0, cur.op4}, {31'd0, e.op4});
            chk("rd", {27'd0, cur.rd}, {27'd0, e.rd});
            chk("illegal", {31'd0, cur.ill}, {31'd0, e.ill});
            chk("cin", {31'd0, cin}, 32'd0);
          end
        end else begin
          snap = cur;
          have_prev = 1'b1;
        end
      end else begin
        have_prev = 1'b0;
      end
    end else begin
      have_prev = 1'b0;
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_x1"}, x1, 32'd0);
    chk({tag, "_x2"}, x2, 32'd0);
    chk({tag, "_instr"}, {12'd0, instr}, 32'd0);
    chk({tag, "_rd"}, {27'd0, rd}, 32'd0);
    chk({tag, "_flags"}, {29'd0, opcode_4, illegal, cin}, 32'd0);
  endtask

  initial begin
    logic [31:0] ins;
    logic [6:0]  opc;
    int          drain;
    for (int i = 0; i < 32; i++) regs[i] = '0;

    #2 rst_n = 1'b0;
    #1 check_reset_state("reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Writeback then register-register read
    cycle(1'b0, 32'd0, 1'b1, 5'd5, 32'h0000_00AA, 1'b1);
    cycle(1'b0, 32'd0, 1'b1, 5'd6, 32'h0000_0055, 1'b1);
    cycle(1'b1, 32'h0062_83B3, 1'b0, 5'd0, 32'd0, 1'b1);
    // Same-cycle writeback and reader
    cycle(1'b1, 32'h0012_8413, 1'b1, 5'd5, 32'h0000_1234, 1'b1);
    cycle(1'b1, 32'h0012_8413, 1'b0, 5'd0, 32'd0, 1'b1);
    // Back-pressure for three cycles while the next instruction waits
    cycle(1'b1, 32'h0062_83B3, 1'b0, 5'd0, 32'd0, 1'b0);
    cycle(1'b1, make_r(5'd5, 5'd6, 5'd9, 7'h33), 1'b0, 5'd0, 32'd0, 1'b0);
    cycle(1'b1, make_r(5'd5, 5'd6, 5'd9, 7'h33), 1'b0, 5'd0, 32'd0, 1'b0);
    cycle(1'b1, make_r(5'd5, 5'd6, 5'd9, 7'h33), 1'b0, 5'd0, 32'd0, 1'b0);
    cycle(1'b1, make_r(5'd5, 5'd6, 5'd9, 7'h33), 1'b0, 5'd0, 32'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    // x0 writes discarded
    cycle(1'b0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1);
    cycle(1'b1, make_r(5'd5, 5'd0, 5'd1, 7'h33), 1'b0, 5'd0, 32'd0, 1'b1);
    // Illegal opcode (LW) still flows
    cycle(1'b1, 32'h0002_A303, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);

    // Reset while a held instruction is stalled
    cycle(1'b1, 32'h0062_83B3, 1'b0, 5'd0, 32'd0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_state("midreset");
    sb_q.delete();
    for (int i = 0; i < 32; i++) regs[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 32'h0062_83B3, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);

    // Randomized traffic over a small register window to provoke collisions
    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    opc = 7'h33;
        2:       opc = 7'h13;
        default: opc = 7'($urandom);
      endcase
      ins = $urandom;
      ins[6:0]   = opc;
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      cycle(($urandom_range(0, 3) != 0), ins, 1'($urandom), 5'($urandom_range(0, 7)),
            $urandom, ($urandom_range(0, 3) != 0));
    end

    drain = 0;
    while ((sb_q.size() != 0 || out_valid) && drain < 20) begin
      cycle(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
      drain++;
    end
    chk("scoreboard_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
